controle_venda: RTL and testbench

CONTROLE_VENDA -- requirements
Module: controle_venda

---
 rtl/controle_venda_pkg.sv | 34 +++
 rtl/controle_venda_acumulador_saldo.sv | 52 +++++
 rtl/controle_venda.sv | 147 ++++++++++++++
 tb/tb_controle_venda.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_venda_pkg.sv
// controle_venda_pkg -- shared definitions for the vending controller.
//   - FSM state encoding (plain localparam constants)
//   - coin codes and coin values in reais
//   - credit (saldo) width
//   - valor_moeda(): coin code -> value, 0 for the invalid code
package controle_venda_pkg;

  localparam int SALDO_W = 6;

  localparam logic [2:0] OCIOSO = 3'd0;
  localparam logic [2:0] PEDE   = 3'd1;
  localparam logic [2:0] SOMA   = 3'd2;
  localparam logic [2:0] LIBERA = 3'd3;
  localparam logic [2:0] VENDE  = 3'd4;

  localparam logic [1:0] MOEDA_5   = 2'd0;
  localparam logic [1:0] MOEDA_10  = 2'd1;
  localparam logic [1:0] MOEDA_20  = 2'd2;
  localparam logic [1:0] MOEDA_INV = 2'd3;

  localparam logic [SALDO_W-1:0] VALOR_5  = 6'd5;
  localparam logic [SALDO_W-1:0] VALOR_10 = 6'd10;
  localparam logic [SALDO_W-1:0] VALOR_20 = 6'd20;

  function automatic logic [SALDO_W-1:0] valor_moeda(input logic [1:0] codigo);
    case (codigo)
      MOEDA_5:  valor_moeda = VALOR_5;
      MOEDA_10: valor_moeda = VALOR_10;
      MOEDA_20: valor_moeda = VALOR_20;
      default:  valor_moeda = '0;
    endcase
  endfunction

endpackage

// File: rtl/controle_venda_acumulador_saldo.sv
// acumulador_saldo -- credit accumulator of the vending controller.
// Adds the value of the captured coin when soma_i is high, clears on limpa_i,
// and raises a one-cycle rejeitada_o when the captured coin is invalid.
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   soma_i       add the coin in moeda_i this cycle
//   limpa_i      clear the credit (end of sale)
//   moeda_i      captured coin code
//   saldo_o      accumulated credit in reais (registered)
//   rejeitada_o  one-cycle pulse for an invalid coin (registered)
module acumulador_saldo
  import controle_venda_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               soma_i,
  input  logic               limpa_i,
  input  logic [1:0]         moeda_i,
  output logic [SALDO_W-1:0] saldo_o,
  output logic               rejeitada_o
);

  logic [SALDO_W-1:0] saldo_q, saldo_d;
  logic               rej_q, rej_d;

  // Legal prices keep saldo <= PRECO+15 <= 63, so the add never wraps.
  always_comb begin
    saldo_d = saldo_q;
    rej_d   = 1'b0;
    if (limpa_i) begin
      saldo_d = '0;
    end else if (soma_i) begin
      saldo_d = saldo_q + valor_moeda(moeda_i);
      rej_d   = (moeda_i == MOEDA_INV);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      saldo_q <= '0;
      rej_q   <= 1'b0;
    end else begin
      saldo_q <= saldo_d;
      rej_q   <= rej_d;
    end
  end

  assign saldo_o     = saldo_q;
  assign rejeitada_o = rej_q;

endmodule

// File: rtl/controle_venda.sv
// controle_venda -- coin-operated vending controller.
// Requests coins one at a time (next), accumulates credit, and pulses vendeu
// for TEMPO_VENDA cycles once saldo reaches PRECO. Excess credit is dropped.
// Optional feature macro: CONTROLE_VENDA_TROCO_EN adds the troco output
// (saldo-PRECO latched on sale entry, held during the sale, 0 otherwise).
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   moeda         coin code (0=5, 1=10, 2=20, 3=invalid)
//   moeda_valida  buyer strobe, held while moeda is stable
//   next          coin request; one coin per 0->1 edge
//   vendeu        sale in progress
//   saldo         accumulated credit in reais
//   rejeitada     one-cycle pulse when an invalid coin is taken
//   expirou       one-cycle pulse when a request times out
//   troco         change value (only with CONTROLE_VENDA_TROCO_EN)
//   estado_dbg    current FSM state
// Handshake: next rises in PEDE; the buyer raises moeda_valida with a stable
// coin; the coin is taken on the first edge with moeda_valida high and next
// drops; the buyer then drops moeda_valida, which LIBERA waits for before
// deciding between a sale and a new request (four-phase).
module controle_venda
  import controle_venda_pkg::*;
#(
  parameter int PRECO       = 40,
  parameter int TEMPO_VENDA = 4,
  parameter int TIMEOUT     = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         moeda,
  input  logic               moeda_valida,
  output logic               next,
  output logic               vendeu,
  output logic [SALDO_W-1:0] saldo,
  output logic               rejeitada,
  output logic               expirou,
`ifdef CONTROLE_VENDA_TROCO_EN
  output logic [SALDO_W-1:0] troco,
`endif
  output logic [2:0]         estado_dbg
);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;      // PEDE wait counter / VENDE length counter
  logic       armed_q;           // low only for the first edge after reset
  logic [1:0] moeda_q;
  logic       next_q, vendeu_q, expirou_q, expirou_d;
  logic       soma, limpa;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    expirou_d = 1'b0;
    limpa     = 1'b0;
    case (state_q)
      // The first edge after reset release is spent here so that next
      // cannot rise on an edge that may coincide with reset deassertion.
      OCIOSO: if (armed_q) state_d = PEDE;
      PEDE: begin
        if (moeda_valida) begin
          state_d = SOMA;
          cnt_d   = '0;
        end else if (cnt_q == 4'(TIMEOUT - 1)) begin
          state_d   = OCIOSO;
          cnt_d     = '0;
          expirou_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SOMA: state_d = LIBERA;
      LIBERA: begin
        if (!moeda_valida) state_d = (saldo >= SALDO_W'(PRECO)) ? VENDE : PEDE;
      end
      VENDE: begin
        if (cnt_q == 4'(TEMPO_VENDA - 1)) begin
          state_d = PEDE;
          cnt_d   = '0;
          limpa   = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = OCIOSO;
        cnt_d   = '0;
      end
    endcase
  end

  assign soma = (state_q == SOMA);

  // Moore outputs are registered from the next state so they line up with
  // the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= OCIOSO;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      moeda_q   <= '0;
      next_q    <= 1'b0;
      vendeu_q  <= 1'b0;
      expirou_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      armed_q   <= 1'b1;
      if (state_q == PEDE && moeda_valida) moeda_q <= moeda;
      next_q    <= (state_d == PEDE);
      vendeu_q  <= (state_d == VENDE);
      expirou_q <= expirou_d;
    end
  end

  acumulador_saldo u_acumulador (
    .clk_i       (clk),
    .rst_ni      (reset),
    .soma_i      (soma),
    .limpa_i     (limpa),
    .moeda_i     (moeda_q),
    .saldo_o     (saldo),
    .rejeitada_o (rejeitada)
  );

`ifdef CONTROLE_VENDA_TROCO_EN
  logic [SALDO_W-1:0] troco_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      troco_q <= '0;
    end else if (state_d == VENDE) begin
      if (state_q != VENDE) troco_q <= saldo - SALDO_W'(PRECO);
    end else begin
      troco_q <= '0;
    end
  end

  assign troco = troco_q;
`endif

  assign next       = next_q;
  assign vendeu     = vendeu_q;
  assign expirou    = expirou_q;
  assign estado_dbg = state_q;

endmodule

// File: tb/tb_controle_venda.sv
// tb_controle_venda -- directed bench for controle_venda.
// Driver tasks play the buyer and push the events they expect into exp_q;
// a negedge monitor turns DUT activity into events and compares them in order.
// Event word: {kind[3:0], aux[5:0], saldo[5:0]}.
module tb_controle_venda;

  localparam int PRECO       = 40;
  localparam int TEMPO_VENDA = 4;
  localparam int TIMEOUT     = 15;

  localparam logic [3:0] K_SALDO = 4'd1;  // saldo changed to a nonzero value
  localparam logic [3:0] K_REJ   = 4'd2;  // rejeitada high
  localparam logic [3:0] K_EXP   = 4'd3;  // expirou high, aux = last next-high run
  localparam logic [3:0] K_VEND  = 4'd4;  // vendeu rose, aux = troco (0 without it)
  localparam logic [3:0] K_FIM   = 4'd5;  // vendeu fell, aux = vendeu-high run
  localparam logic [3:0] K_NEXT  = 4'd6;  // next rose, aux = preceding low run

  logic       clk;
  logic       reset;
  logic [1:0] moeda;
  logic       moeda_valida;
  logic       next;
  logic       vendeu;
  logic [5:0] saldo;
  logic       rejeitada;
  logic       expirou;
  logic [2:0] estado_dbg;
`ifdef CONTROLE_VENDA_TROCO_EN
  logic [5:0] troco;
`endif

  controle_venda #(.PRECO(PRECO), .TEMPO_VENDA(TEMPO_VENDA), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .moeda        (moeda),
    .moeda_valida (moeda_valida),
    .next         (next),
    .vendeu       (vendeu),
    .saldo        (saldo),
    .rejeitada    (rejeitada),
    .expirou      (expirou),
`ifdef CONTROLE_VENDA_TROCO_EN
    .troco        (troco),
`endif
    .estado_dbg   (estado_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int m_saldo = 0;

  function automatic void push(input logic [3:0] k, input int aux, input int s);
    exp_q.push_back({k, 6'(aux), 6'(s)});
  endfunction

  task automatic observe(input logic [3:0] k, input logic [5:0] aux, input logic [5:0] s);
    logic [15:0] got, want;
    got = {k, aux, s};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d aux=%0d saldo=%0d, none expected", k, aux, s);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        bad++;
        $display("FAIL event: got kind=%0d aux=%0d saldo=%0d, expected kind=%0d aux=%0d saldo=%0d",
                 k, aux, s, want[15:12], want[11:6], want[5:0]);
      end
    end
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  // ---------------- monitor ----------------
  logic prev_next, prev_vendeu;
  logic [5:0] prev_saldo;
  int low_run, high_run, last_high, vend_run;

  always @(negedge clk) begin
    logic [5:0] troco_obs;
    if (!reset) begin
      prev_next   = 1'b0;
      prev_vendeu = 1'b0;
      prev_saldo  = '0;
      low_run     = 0;
      high_run    = 0;
      last_high   = 0;
      vend_run    = 0;
    end else begin
`ifdef CONTROLE_VENDA_TROCO_EN
      troco_obs = troco;
`else
      troco_obs = '0;
`endif
      if (next) high_run++;
      else if (prev_next) begin
        last_high = high_run;
        high_run  = 0;
      end
      if (vendeu) vend_run++;
      if (saldo !== prev_saldo && saldo !== 6'd0) observe(K_SALDO, 6'd0, saldo);
      if (rejeitada) observe(K_REJ, 6'd0, saldo);
      if (expirou) observe(K_EXP, 6'(last_high), saldo);
      if (vendeu && !prev_vendeu) observe(K_VEND, troco_obs, saldo);
      if (!vendeu && prev_vendeu) begin
        observe(K_FIM, 6'(vend_run), saldo);
        vend_run = 0;
      end
      if (next && !prev_next) begin
        observe(K_NEXT, 6'(low_run), saldo);
        low_run = 0;
      end
      if (!next) low_run++;
      prev_next   = next;
      prev_vendeu = vendeu;
      prev_saldo  = saldo;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic int coin_val(input logic [1:0] code);
    case (code)
      2'd0: return 5;
      2'd1: return 10;
      2'd2: return 20;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_troco(input int s);
`ifdef CONTROLE_VENDA_TROCO_EN
    return s - PRECO;
`else
    return 0 * s;
`endif
  endfunction

  task automatic wait_next(input logic v, input int lim, input string what);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (next !== v && n < lim);
    if (next !== v) begin
      total++;
      bad++;
      $display("FAIL wait_%s: next=%b expected %b within %0d cycles", what, next, v, lim);
    end
  endtask

  // Assert reset a little after a negedge, check outputs with no clock edge,
  // then release mid-cycle; next must rise one cycle later than a plain restart.
  task automatic reset_check(input string tag);
    #2;
    reset        = 1'b0;
    moeda_valida = 1'b0;
    #1;
    check({tag, "_vendeu"}, {5'd0, vendeu}, 6'd0);
    check({tag, "_next"}, {5'd0, next}, 6'd0);
    check({tag, "_saldo"}, saldo, 6'd0);
    check({tag, "_rejeitada"}, {5'd0, rejeitada}, 6'd0);
    check({tag, "_expirou"}, {5'd0, expirou}, 6'd0);
`ifdef CONTROLE_VENDA_TROCO_EN
    check({tag, "_troco"}, troco, 6'd0);
`endif
    repeat (2) @(negedge clk);
    m_saldo = 0;
    push(K_NEXT, 1, 0);
    #2;
    reset = 1'b1;
  endtask

  task automatic coin(input logic [1:0] code, input bit cut);
    bit vend;
    int n;
    wait_next(1'b1, 40, "rise");
    if (code == 2'd3) push(K_REJ, 0, m_saldo);
    else begin
      m_saldo = m_saldo + coin_val(code);
      push(K_SALDO, 0, m_saldo);
    end
    vend = (m_saldo >= PRECO);
    if (vend) begin
      push(K_VEND, exp_troco(m_saldo), m_saldo);
      if (!cut) begin
        push(K_FIM, TEMPO_VENDA, 0);
        push(K_NEXT, 2 + TEMPO_VENDA, 0);
        m_saldo = 0;
      end
    end else begin
      push(K_NEXT, 2, m_saldo);
    end
    moeda        = code;
    moeda_valida = 1'b1;
    wait_next(1'b0, 5, "fall");
    moeda_valida = 1'b0;
    moeda        = 2'($urandom_range(0, 3));
    if (vend) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (vendeu !== 1'b1 && n < 8);
      if (vendeu !== 1'b1) begin
        total++;
        bad++;
        $display("FAIL wait_vendeu: vendeu=%b expected 1 within 8 cycles", vendeu);
      end
      if (cut) reset_check("reset_mid_sale");
      else begin
        // A strobe during the sale must be ignored.
        moeda        = 2'd2;
        moeda_valida = 1'b1;
        @(negedge clk);
        moeda_valida = 1'b0;
      end
    end
  endtask

  task automatic timeout_wait();
    wait_next(1'b1, 40, "rise_to");
    push(K_EXP, TIMEOUT, m_saldo);
    push(K_NEXT, 1, m_saldo);
    wait_next(1'b0, TIMEOUT + 5, "fall_to");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset        = 1'b1;
    moeda        = 2'd0;
    moeda_valida = 1'b0;
    reset_check("reset_init");

    // 20 + 20 -> sale
    coin(2'd2, 0);
    coin(2'd2, 0);
    // 5, 10, 20, 5 -> 5, 15, 35, 40 -> sale
    coin(2'd0, 0);
    coin(2'd1, 0);
    coin(2'd2, 0);
    coin(2'd0, 0);
    // invalid coin, then 20 + 20
    coin(2'd3, 0);
    coin(2'd2, 0);
    coin(2'd2, 0);
    // timeouts keep saldo; overpayment 35 + 20 = 55 still sells
    timeout_wait();
    coin(2'd2, 0);
    timeout_wait();
    coin(2'd1, 0);
    coin(2'd0, 0);
    coin(2'd2, 0);
    // reset in the middle of a sale at saldo 40, then restart
    coin(2'd2, 0);
    coin(2'd2, 1);
    coin(2'd1, 0);
    coin(2'd1, 0);
    coin(2'd1, 0);
    coin(2'd1, 0);

    repeat (12) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_events: got %0d left in queue expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
